// File: rtl/reaction_pkg.sv
// Shared types and constants for the reaction timer: FSM states, LFSR
// seed/taps and the BCD display limits.
package reaction_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_GO   = 3'd2,
    ST_DONE = 3'd3,
    ST_FOUL = 3'd4
  } state_e;

  // Fibonacci LFSR x^16 + x^14 + x^13 + x^11 + 1 (bits 15, 13, 12, 10)
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam logic [15:0] BCD_MAX  = 16'h9999;
  localparam logic [15:0] BCD_ZERO = 16'h0000;

  function automatic logic [15:0] lfsr_next(input logic [15:0] q);
    return {q[14:0], ^(q & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/bcd_counter4.sv
// Four-digit BCD counter with synchronous clear and an increment that
// saturates at 9999; sat reports that the counter sits at 9999.
module bcd_counter4
  import reaction_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        inc,
  output logic [15:0] value,
  output logic        sat
);

  logic [15:0] value_q;
  logic [15:0] value_d;

  assign sat   = (value_q == BCD_MAX);
  assign value = value_q;

  // Next value: clear wins, otherwise ripple a decimal carry from digit 0
  always_comb begin
    logic carry;
    value_d = value_q;
    carry   = 1'b1;
    if (clear) begin
      value_d = BCD_ZERO;
    end else if (inc && !sat) begin
      for (int i = 0; i < 4; i++) begin
        if (carry) begin
          if (value_q[4*i +: 4] >= 4'd9) begin
            value_d[4*i +: 4] = 4'd0;
          end else begin
            value_d[4*i +: 4] = value_q[4*i +: 4] + 4'd1;
            carry             = 1'b0;
          end
        end
      end
    end
  end

  // Counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) value_q <= BCD_ZERO;
    else        value_q <= value_d;
  end

endmodule

// File: rtl/reaction_timer.sv
// Reaction timer: random wait after start, then measures in ms how long the
// player takes to raise stop; tracks the best valid time since reset.
module reaction_timer
  import reaction_pkg::*;
#(
  parameter int CLK_HZ       = 50_000_000,
  parameter int TICK_DIV     = 50_000,
  parameter int MIN_DELAY_MS = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stop,
  output logic        go_led,
  output logic [15:0] time_bcd,
  output logic [15:0] best_bcd,
  output logic        done,
  output logic        foul
);

  // A ms tick can never be longer than one second of clocks.
  localparam int          TICK_LIM  = (TICK_DIV > CLK_HZ) ? CLK_HZ : TICK_DIV;
  localparam logic [31:0] TICK_LAST = 32'(TICK_LIM - 1);

  logic        rst_meta_q, rst_sync_q, rst_int_n;
  logic        start_meta_q, start_meta_d, start_sync_q, start_sync_d;
  logic        start_prev_q, start_prev_d, stop_meta_q, stop_meta_d;
  logic        stop_sync_q, stop_sync_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [31:0] tick_cnt_q, tick_cnt_d;
  logic [15:0] delay_q, delay_d;
  logic [15:0] best_q, best_d;
  logic        go_led_q, go_led_d, done_q, done_d, foul_q, foul_d;
  state_e      state_q, state_d;
  logic        start_edge, tick, cnt_clear, cnt_inc, cnt_sat;
  logic [15:0] cnt_value;

  // Reset synchroniser: asserts immediately, releases on the clock
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) {rst_meta_q, rst_sync_q} <= 2'b00;
    else        {rst_meta_q, rst_sync_q} <= {1'b1, rst_meta_q};
  end
  assign rst_int_n = rst_sync_q;

  // Input synchronisers and free-running LFSR
  always_comb begin
    start_meta_d = start;
    start_sync_d = start_meta_q;
    start_prev_d = start_sync_q;
    stop_meta_d  = stop;
    stop_sync_d  = stop_meta_q;
    lfsr_d       = lfsr_next(lfsr_q);
  end

  assign start_edge = start_sync_q & ~start_prev_q;
  assign tick       = (tick_cnt_q == TICK_LAST);

  // Next state, wait/tick counters, time counter control and best time
  always_comb begin
    state_d    = state_q;
    delay_d    = delay_q;
    best_d     = best_q;
    cnt_clear  = 1'b0;
    cnt_inc    = 1'b0;
    tick_cnt_d = tick ? 32'd0 : tick_cnt_q + 32'd1;
    case (state_q)
      ST_IDLE, ST_DONE, ST_FOUL: begin
        if (start_edge) begin
          state_d = ST_WAIT;
          delay_d = 16'(MIN_DELAY_MS) + {5'd0, lfsr_q[10:0]};
        end
      end
      ST_WAIT: begin
        if (stop_sync_q) begin
          state_d = ST_FOUL;
        end else if (tick) begin
          if (delay_q <= 16'd1) begin
            state_d   = ST_GO;
            delay_d   = 16'd0;
            cnt_clear = 1'b1;
          end else begin
            delay_d = delay_q - 16'd1;
          end
        end
      end
      ST_GO: begin
        // stop beats a coinciding tick; a saturated count is a timeout
        if (stop_sync_q || cnt_sat) begin
          state_d = ST_DONE;
          if (cnt_value < best_q && cnt_value != BCD_MAX) best_d = cnt_value;
        end else if (tick) begin
          cnt_inc = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (state_d != state_q && (state_d == ST_WAIT || state_d == ST_GO)) begin
      tick_cnt_d = 32'd0;
    end
    go_led_d = (state_d == ST_GO);
    done_d   = (state_d == ST_DONE);
    foul_d   = (state_d == ST_FOUL);
  end

  // State register
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  // Synchronisers, LFSR, counters, best time and registered indicators
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      start_meta_q <= 1'b0;
      start_sync_q <= 1'b0;
      start_prev_q <= 1'b0;
      stop_meta_q  <= 1'b0;
      stop_sync_q  <= 1'b0;
      lfsr_q       <= LFSR_SEED;
      tick_cnt_q   <= 32'd0;
      delay_q      <= 16'd0;
      best_q       <= BCD_MAX;
      go_led_q     <= 1'b0;
      done_q       <= 1'b0;
      foul_q       <= 1'b0;
    end else begin
      start_meta_q <= start_meta_d;
      start_sync_q <= start_sync_d;
      start_prev_q <= start_prev_d;
      stop_meta_q  <= stop_meta_d;
      stop_sync_q  <= stop_sync_d;
      lfsr_q       <= lfsr_d;
      tick_cnt_q   <= tick_cnt_d;
      delay_q      <= delay_d;
      best_q       <= best_d;
      go_led_q     <= go_led_d;
      done_q       <= done_d;
      foul_q       <= foul_d;
    end
  end

  bcd_counter4 u_time (
    .clk   (clk),
    .rst_n (rst_int_n),
    .clear (cnt_clear),
    .inc   (cnt_inc),
    .value (cnt_value),
    .sat   (cnt_sat)
  );

  assign time_bcd = cnt_value;
  assign best_bcd = best_q;
  assign go_led   = go_led_q;
  assign done     = done_q;
  assign foul     = foul_q;

endmodule

// File: tb/tb_reaction_timer.sv
// Self-checking bench for reaction_timer with randomized stop timing.
module tb_reaction_timer;

  localparam int TD       = 2;   // clocks per ms tick
  localparam int MIN_MS   = 5;
  localparam int SYNC_LAT = 2;   // clocks for stop to cross the synchroniser

  logic        clk = 1'b0;
  logic        rst_n, start, stop;
  logic        go_led, done, foul;
  logic [15:0] time_bcd, best_bcd;

  int n_cmp    = 0;
  int n_bad    = 0;
  int excl_err = 0;
  int best_m   = 9999;
  int time_m   = 0;

  reaction_timer #(
    .CLK_HZ       (50_000_000),
    .TICK_DIV     (TD),
    .MIN_DELAY_MS (MIN_MS)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .stop     (stop),
    .go_led   (go_led),
    .time_bcd (time_bcd),
    .best_bcd (best_bcd),
    .done     (done),
    .foul     (foul)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (rst_n && (int'(go_led) + int'(done) + int'(foul) > 1)) excl_err++;

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    r = {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    return r;
  endfunction

  function automatic int bcd_val(input logic [15:0] b);
    int v = 0;
    for (int i = 3; i >= 0; i--) begin
      if (b[4*i +: 4] > 4'd9) return -1;
      v = v * 10 + int'(b[4*i +: 4]);
    end
    return v;
  endfunction

  // Stop raised d clocks after go_led is seen reaches the design SYNC_LAT
  // clocks later; every whole tick period of GO elapsed by then is one ms.
  function automatic int exp_ms(input int d);
    int r = (d + SYNC_LAT) / TD;
    return (r > 9999) ? 9999 : r;
  endfunction

  function automatic int d_for(input int ms);
    return ms * TD - SYNC_LAT;
  endfunction

  task automatic press_start();
    start = 1'b1;
    repeat (4) @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_go(input bit pulse_wait);
    int cyc = 0;
    while (!go_led && cyc < 5000) begin
      if (pulse_wait && cyc == 2) start = 1'b1;
      if (pulse_wait && cyc == 4) start = 1'b0;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk("go_rise", go_led, 1'b1);
    chk("wait_len", 32'((cyc + 4 >= MIN_MS * TD) && (cyc + 4 <= (MIN_MS + 2047) * TD + 8)), 1);
    chk("go_entry_clear", time_bcd, 16'h0000);
  endtask

  task automatic play(input string tag, input int d, input bit pw, input bit pg);
    int e;
    int cyc = 0;
    press_start();
    wait_go(pw);
    for (int i = 0; i < d; i++) begin
      if (pg && i == 2) start = 1'b1;
      if (pg && i == 5) start = 1'b0;
      @(negedge clk);
    end
    stop = 1'b1;
    while (!done && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    e = exp_ms(d);
    time_m = e;
    if (e < best_m && e != 9999) best_m = e;
    chk({tag, "_done"}, done, 1'b1);
    chk({tag, "_go_off"}, go_led, 1'b0);
    chk({tag, "_time"}, time_bcd, to_bcd(time_m));
    chk({tag, "_best"}, best_bcd, to_bcd(best_m));
    stop = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    int go_seen, seq_err, cyc, prev_v;
    logic [15:0] prev;
    rst_n = 1'b0;
    start = 1'b0;
    stop  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_go", go_led, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_foul", foul, 1'b0);
    chk("rst_time", time_bcd, 16'h0000);
    chk("rst_best", best_bcd, 16'h9999);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    play("r37", d_for(37), 1'b0, 1'b0);
    play("r52", d_for(52), 1'b0, 1'b0);
    play("r21", d_for(21), 1'b0, 1'b0);

    // false start: stop rises during the wait
    press_start();
    stop    = 1'b1;
    go_seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (go_led) go_seen++;
    end
    chk("foul_flag", foul, 1'b1);
    chk("foul_no_go", go_seen, 0);
    chk("foul_done", done, 1'b0);
    chk("foul_time", time_bcd, to_bcd(time_m));
    chk("foul_best", best_bcd, to_bcd(best_m));
    stop = 1'b0;
    repeat (4) @(negedge clk);

    play("pulses", d_for(30), 1'b1, 1'b1);
    play("collide", 12 * TD - SYNC_LAT - 1, 1'b0, 1'b0);
    for (int r = 0; r < 3; r++) play("rand", int'($urandom_range(6, 400)), 1'b0, 1'b0);

    // timeout: stop never rises
    press_start();
    wait_go(1'b0);
    prev    = time_bcd;
    seq_err = 0;
    cyc     = 0;
    while (!done && cyc < 9999 * TD + 100) begin
      @(negedge clk);
      cyc++;
      if (time_bcd != prev) begin
        prev_v = bcd_val(prev);
        if (bcd_val(time_bcd) < 0 || bcd_val(time_bcd) != prev_v + 1) seq_err++;
        if (prev == 16'h0099) chk("carry_0099", time_bcd, 16'h0100);
        if (prev == 16'h0999) chk("carry_0999", time_bcd, 16'h1000);
        prev = time_bcd;
      end
    end
    time_m = 9999;
    chk("to_done", done, 1'b1);
    chk("to_time", time_bcd, 16'h9999);
    chk("to_best", best_bcd, to_bcd(best_m));
    chk("to_sequence", seq_err, 0);
    repeat (4) @(negedge clk);

    // reset in the middle of GO
    press_start();
    wait_go(1'b0);
    cyc = 0;
    while (time_bcd != 16'h0015 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("reach_0015", time_bcd, 16'h0015);
    rst_n = 1'b0;
    #1;
    best_m = 9999;
    time_m = 0;
    chk("mid_rst_go", go_led, 1'b0);
    chk("mid_rst_done", done, 1'b0);
    chk("mid_rst_foul", foul, 1'b0);
    chk("mid_rst_time", time_bcd, 16'h0000);
    chk("mid_rst_best", best_bcd, 16'h9999);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    play("post_rst", int'($urandom_range(6, 400)), 1'b0, 1'b0);
    chk("exclusive", excl_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/reaction_timer.md
REACTION_TIMER -- requirements
Module: reaction_timer

Interface
REQ-001 Parameter CLK_HZ, default 50_000_000, system clock frequency in Hz.
REQ-002 Parameter TICK_DIV, default 50_000, clock cycles per 1 ms tick; the bench overrides it (e.g. 10).
REQ-003 Parameter MIN_DELAY_MS, default 1000, minimum random wait before GO.
REQ-004 clock  input  1  single system clock; all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  player start button, active-high, asynchronous to clock.
REQ-007 stop  input  1  level from the distance sensor stage, high = hand detected; asynchronous to clock.
REQ-008 go_led  output  1  high while the player must react.
REQ-009 time_bcd  output  16  last reaction time in ms, 4 BCD digits, [15:12] = thousands.
REQ-010 best_bcd  output  16  best valid reaction time since reset, 4 BCD digits.
REQ-011 done  output  1  high while a valid result is displayed.
REQ-012 foul  output  1  high while a false-start result is displayed.

Function
REQ-013 start and stop shall each pass through a 2-flop synchroniser before use; start shall be rising-edge detected after synchronisation.
REQ-014 A free-running ms tick shall pulse for one cycle every TICK_DIV cycles; the tick counter shall restart from 0 on every state entry to WAIT or GO.
REQ-015 A 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1) shall advance every clock cycle.
REQ-016 States: IDLE, WAIT, GO, DONE, FOUL.
REQ-017 IDLE/DONE/FOUL + start edge -> WAIT; delay_ms latched = MIN_DELAY_MS + LFSR[10:0] (range MIN..MIN+2047).
REQ-018 WAIT: delay counter decrements on each tick; synchronised stop high -> FOUL (priority over expiry in the same cycle); counter reaching 0 -> GO.
REQ-019 GO: go_led = 1; time_bcd cleared to 0000 on entry, incremented by 1 in BCD on each tick.
REQ-020 GO: synchronised stop high -> DONE, time_bcd frozen at its current value; stop and tick in the same cycle -> stop wins, no increment.
REQ-021 GO: time_bcd saturates at 9999; reaching 9999 -> DONE with time_bcd = 9999 (timeout).
REQ-022 On entry to DONE, best_bcd <= time_bcd iff time_bcd < best_bcd and time_bcd != 9999.
REQ-023 FOUL: time_bcd shall hold its previous value, best_bcd unchanged, foul = 1.
REQ-024 start edges in WAIT or GO shall be ignored.
REQ-025 go_led, done and foul shall be registered, glitch-free, mutually exclusive.
REQ-026 BCD increment: digit 9 wraps to 0 with carry into the next digit; no digit ever exceeds 9.

Reset
REQ-027 Reset low shall asynchronously force: state IDLE, go_led 0, done 0, foul 0, time_bcd 0000, best_bcd 9999, LFSR seed, tick and delay counters 0, synchronisers 0.
REQ-028 Reset asserted mid-round (WAIT or GO) shall abort the round with no best_bcd update; release shall be synchronous to clock via the reset-sync already used in the codebase.

Structure
REQ-029 Package reaction_pkg shall hold the state enumeration, LFSR seed/taps, and the BCD constants 9999 and 0000.
REQ-030 One sub-module bcd_counter4 (clear, inc, saturating 4-digit BCD, sat flag) shall implement time_bcd; everything else stays in reaction_timer.

Verification (TICK_DIV = 10, MIN_DELAY_MS = 5)
REQ-031 Reset, start edge, hold stop low, raise stop 37 ticks after go_led -> done = 1, time_bcd = 0037, best_bcd = 0037.
REQ-032 Second round, stop after 52 ticks -> time_bcd = 0052, best_bcd stays 0037; third round at 21 ticks -> best_bcd = 0021.
REQ-033 Start, raise stop during WAIT -> foul = 1, go_led never rises, time_bcd and best_bcd unchanged.
REQ-034 Start, never raise stop -> time_bcd = 9999 exactly, done = 1, best_bcd unchanged; check 0099 -> 0100 and 0999 -> 1000 carries on the way.
REQ-035 Pull reset low during GO at time_bcd = 0015 -> all outputs reset values immediately, best_bcd = 9999.
REQ-036 Start pulses during WAIT and GO -> no restart; stop and tick in the same cycle -> value not incremented.
